// File: rtl/jpc_fetch_pkg.sv
// Shared types and constants for the jpc fetch sequencer.
package jpc_fetch_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_HOLD  = 3'd4
  } fetch_state_e;

  // Instructions are word aligned: redirect targets drop the two low bits.
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/jpc_fetch_ctrl.sv
// Fetch sequencer for jpc_pc: steps/redirects the PC, issues one imem request
// at a time and hands fetched words to decode over valid/ready.
module jpc_fetch_ctrl
  import jpc_fetch_pkg::*;
#(
  parameter int unsigned JPC_ADDRESS_WIDTH = 32,
  parameter int unsigned JPC_DATA_WIDTH    = 32,
  parameter logic [JPC_ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned PC_INCREMENT      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [JPC_ADDRESS_WIDTH-1:0] pc_I,
  output logic [JPC_ADDRESS_WIDTH-1:0] next_pc_O,
  output logic                         pc_enable_O,
  output logic                         imem_req_O,
  output logic [JPC_ADDRESS_WIDTH-1:0] imem_addr_O,
  input  logic                         imem_ack_I,
  input  logic [JPC_DATA_WIDTH-1:0]    imem_rdata_I,
  output logic                         instr_valid_O,
  output logic [JPC_DATA_WIDTH-1:0]    instr_O,
  output logic [JPC_ADDRESS_WIDTH-1:0] instr_pc_O,
  input  logic                         instr_ready_I,
  input  logic                         redirect_I,
  input  logic [JPC_ADDRESS_WIDTH-1:0] redirect_pc_I,
  input  logic                         stall_I,
  output logic                         misaligned_O
);

  localparam logic [JPC_ADDRESS_WIDTH-1:0] ALIGN_MASK = JPC_ADDRESS_WIDTH'(PC_ALIGN_MASK);
  localparam logic [JPC_ADDRESS_WIDTH-1:0] PC_STEP    = JPC_ADDRESS_WIDTH'(PC_INCREMENT);

  fetch_state_e state_q, state_d;

  logic [JPC_ADDRESS_WIDTH-1:0] fetch_addr_q;
  logic [JPC_DATA_WIDTH-1:0]    instr_q;
  logic [JPC_ADDRESS_WIDTH-1:0] instr_pc_q;
  logic                         misaligned_q;

  logic [JPC_ADDRESS_WIDTH-1:0] redirect_tgt;
  logic                         redirect_odd;
  logic                         redirect_take;
  logic                         load_fetch_addr;
  logic                         capture;
  logic [JPC_ADDRESS_WIDTH-1:0] capture_pc;

  assign redirect_tgt = redirect_pc_I & ALIGN_MASK;
  assign redirect_odd = |(redirect_pc_I & ~ALIGN_MASK);

  always_comb begin
    state_d         = state_q;
    next_pc_O       = pc_I + PC_STEP;
    pc_enable_O     = 1'b0;
    imem_req_O      = 1'b0;
    imem_addr_O     = '0;
    instr_valid_O   = 1'b0;
    redirect_take   = 1'b0;
    load_fetch_addr = 1'b0;
    capture         = 1'b0;
    capture_pc      = pc_I;

    unique case (state_q)
      S_INIT: begin
        pc_enable_O = 1'b1;
        next_pc_O   = RESET_VECTOR;
        state_d     = S_FETCH;
      end

      S_FETCH: begin
        if (redirect_I) begin
          pc_enable_O   = 1'b1;
          next_pc_O     = redirect_tgt;
          redirect_take = 1'b1;
        end else if (!stall_I) begin
          imem_req_O      = 1'b1;
          imem_addr_O     = pc_I;
          load_fetch_addr = 1'b1;
          if (imem_ack_I) begin
            capture     = 1'b1;
            capture_pc  = pc_I;
            pc_enable_O = 1'b1;
            next_pc_O   = pc_I + PC_STEP;
            state_d     = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        imem_req_O  = 1'b1;
        imem_addr_O = fetch_addr_q;
        if (redirect_I) begin
          pc_enable_O   = 1'b1;
          next_pc_O     = redirect_tgt;
          redirect_take = 1'b1;
          state_d       = imem_ack_I ? S_FETCH : S_FLUSH;
        end else if (imem_ack_I) begin
          capture     = 1'b1;
          capture_pc  = fetch_addr_q;
          pc_enable_O = 1'b1;
          next_pc_O   = fetch_addr_q + PC_STEP;
          state_d     = S_HOLD;
        end
      end

      // Drain the abandoned request; its data never reaches decode.
      S_FLUSH: begin
        imem_req_O  = 1'b1;
        imem_addr_O = fetch_addr_q;
        if (redirect_I) begin
          pc_enable_O   = 1'b1;
          next_pc_O     = redirect_tgt;
          redirect_take = 1'b1;
        end
        if (imem_ack_I) state_d = S_FETCH;
      end

      S_HOLD: begin
        instr_valid_O = 1'b1;
        if (redirect_I) begin
          pc_enable_O   = 1'b1;
          next_pc_O     = redirect_tgt;
          redirect_take = 1'b1;
          state_d       = S_FETCH;
        end else if (instr_ready_I) begin
          state_d = S_FETCH;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_INIT;
      fetch_addr_q <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= redirect_take && redirect_odd;
      if (load_fetch_addr) fetch_addr_q <= pc_I;
      if (capture) begin
        instr_q    <= imem_rdata_I;
        instr_pc_q <= capture_pc;
      end
    end
  end

  assign instr_O      = instr_q;
  assign instr_pc_O   = instr_pc_q;
  assign misaligned_O = misaligned_q;

endmodule

// File: doc/jpc_fetch_ctrl.md
Name: jpc_fetch_ctrl

Overview:
- Fetch sequencer for the program counter register jpc_pc.
- Drives jpc_pc's next_pc_I and pc_enable_I, and issues one instruction-memory request at a time using the current PC.
- Presents the fetched instruction to decode over a valid/ready handshake.
- Applies branch/jump redirects and stalls. At most one memory request is in flight.

Parameters:
- JPC_ADDRESS_WIDTH, 32, width of PC and memory address.
- JPC_DATA_WIDTH, 32, instruction word width.
- RESET_VECTOR, 0, PC value loaded after reset.
- PC_INCREMENT, 4, sequential PC step.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- pc_I  in  AW  current PC from jpc_pc (pc_O).
- next_pc_O  out  AW  to jpc_pc next_pc_I.
- pc_enable_O  out  1  to jpc_pc pc_enable_I.
- imem_req_O  out  1  memory request.
- imem_addr_O  out  AW  request address.
- imem_ack_I  in  1  memory response valid.
- imem_rdata_I  in  DW  response data.
- instr_valid_O  out  1  instruction valid to decode.
- instr_O  out  DW  instruction word.
- instr_pc_O  out  AW  address of instr_O.
- instr_ready_I  in  1  decode accepts instruction.
- redirect_I  in  1  load PC with redirect_pc_I.
- redirect_pc_I  in  AW  redirect target.
- stall_I  in  1  suppress new requests.
- misaligned_O  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Behaviour:
- Clock and reset:
  - Single clock domain. rst is synchronous and active-low: sampled on clk rising edge, active when 0.
  - rst=0 at any time, including mid-request, gives state=INIT, instr_valid_O=0, misaligned_O=0, instruction registers=0.
  - Any in-flight ack is dropped.
- FSM states: INIT, FETCH, WAIT, FLUSH, HOLD. Default outputs are 0. next_pc_O is always driven (pc_I+PC_INCREMENT when not otherwise specified).
- INIT:
  - pc_enable_O=1, next_pc_O=RESET_VECTOR.
  - First edge with rst=1 goes to FETCH. INIT lasts exactly one cycle after reset release.
  - redirect_I is ignored.
- FETCH:
  - If redirect_I: pc_enable_O=1, next_pc_O=target, imem_req_O=0; stay in FETCH.
  - Else if stall_I: imem_req_O=0, pc_enable_O=0; stay in FETCH.
  - Else: imem_req_O=1, imem_addr_O=pc_I, and fetch_addr_q<=pc_I.
    - Ack in the same cycle: capture imem_rdata_I into instr_O and pc_I into instr_pc_O; pc_enable_O=1; next_pc_O=pc_I+PC_INCREMENT; go to HOLD.
    - No ack: go to WAIT.
- WAIT:
  - imem_req_O=1 and imem_addr_O=fetch_addr_q, held stable until ack. stall_I is ignored.
  - On ack without redirect: same capture and PC step as FETCH, using fetch_addr_q; go to HOLD.
  - On redirect: PC loads target. With ack the same cycle, the data is dropped and the FSM goes to FETCH; without ack, it goes to FLUSH.
- FLUSH:
  - imem_req_O=1 with imem_addr_O=fetch_addr_q until ack. Response data is discarded.
  - Ack goes to FETCH.
  - A redirect here loads PC again; stay in FLUSH unless ack.
- HOLD:
  - instr_valid_O=1; instr_O and instr_pc_O stable.
  - valid&ready goes to FETCH.
  - Redirect in HOLD: PC loads target and the FSM goes to FETCH.
    - If instr_ready_I=1 the same cycle, the transfer counts.
    - Otherwise the instruction is killed: instr_valid_O=0 next cycle.
- Redirect target rules:
  - Bits [1:0] are forced to 0.
  - If they were nonzero, misaligned_O=1 on the following cycle only.
- Arithmetic: PC increment is modulo 2^AW; 0xFFFFFFFC+4 wraps to 0.
- Latency and throughput:
  - Ack to instr_valid_O is 1 cycle.
  - Peak throughput is one instruction per 2 cycles (zero-wait memory, ready held high).
- Priority: rst > redirect_I > imem_ack_I > stall_I.

Decomposition:
- Package jpc_fetch_pkg:
  - state encoding enum (INIT=0, FETCH=1, WAIT=2, FLUSH=3, HOLD=4, 3 bits);
  - PC_ALIGN_MASK constant.
- No sub-module. jpc_pc stays external and is instantiated alongside in the integration bench.

Test Plan:
- Reset release, zero-wait memory returning 0x13, ready=1 -> pc 0,4,8 on successive fetches; instr_pc_O 0 then 4; instr_valid_O high every second cycle.
- Memory acks after 3 cycles -> imem_req_O held 3 cycles with imem_addr_O constant at 0x0; instr_valid_O one cycle after ack; pc 0x0 -> 0x4 at ack.
- Redirect to 0x100 while in WAIT, ack 2 cycles later with 0xDEAD -> data never presented; next request addr 0x100; then instr_pc_O=0x100.
- HOLD with ready=0 for 4 cycles, redirect to 0x200 on cycle 2 -> instruction killed, pc=0x200, no valid/ready transfer occurs.
- stall_I=1 for 3 cycles in FETCH at pc 0x100 -> no request, pc stays 0x100; after release, request 0x100 and pc becomes 0x104.
- Redirect to 0x103 -> PC 0x100, misaligned_O pulses one cycle.
- rst=0 mid-WAIT, then release -> instr_valid_O=0, next_pc_O=RESET_VECTOR with pc_enable_O=1 for one cycle, then a fresh fetch at 0x0.
